// File: rtl/demux_1x16_seq.sv
// rtl/demux_1x16_seq.sv - sequenced 1-to-N_OUT serial demultiplexer / deserializer
module demux_1x16_seq #(
  parameter int N_OUT = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             din,
  input  logic             din_valid,
  input  logic [SEL_W-1:0] sel_in,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] sel_cur,
  output logic             busy,
  output logic             done,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N_OUT - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      sel_cur   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // The start-cycle din is deliberately dropped; capture begins next cycle.
          if (start && !mode) begin
            state     <= SCAN;
            busy      <= 1'b1;
            out       <= '0;
            sel_cur   <= '0;
            out_valid <= 1'b0;
          end else if (mode && din_valid) begin
            out[sel_in] <= din;
          end
        end
        SCAN: begin
          if (din_valid) begin
            out[sel_cur] <= din;
            sel_cur      <= sel_cur + SEL_W'(1);
            if (sel_cur == LAST_LANE) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1x16_seq.sv
// tb/tb_demux_1x16_seq.sv - directed self-checking bench for demux_1x16_seq
module tb_demux_1x16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic        din;
  logic        din_valid;
  logic [3:0]  sel_in;
  logic [15:0] out;
  logic [3:0]  sel_cur;
  logic        busy;
  logic        done;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1x16_seq #(.N_OUT(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .din       (din),
    .din_valid (din_valid),
    .sel_in    (sel_in),
    .out       (out),
    .sel_cur   (sel_cur),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Auto-scan of word w (LSB first); optional stall of gap_len cycles before beat gap_at.
  // poke: pulse start / toggle sel_in / mode mid-scan and pulse start in DONE.
  task automatic run_scan(input string tag, input logic [15:0] w, input int gap_at,
                          input int gap_len, input logic poke, input logic start_din);
    start = 1'b1; mode = 1'b0; din = start_din; din_valid = start_din;
    tick();
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1'b1);
    chk({tag, "_out_clear"}, out, 16'h0);
    chk({tag, "_ovalid_clear"}, out_valid, 1'b0);
    for (int j = 0; j < 16; j++) begin
      if (j == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          din_valid = 1'b0; din = 1'b1;
          tick();
          chk({tag, "_gap_sel"}, sel_cur, 32'(gap_at));
          chk({tag, "_gap_done"}, done, 1'b0);
        end
      end
      if (poke) begin
        start  = (j == 8);
        mode   = (j == 10);
        sel_in = 4'(15 - j);
      end
      din = w[j]; din_valid = 1'b1;
      tick();
      start = 1'b0; mode = 1'b0;
      if (j < 15) begin
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_nodone"}, done, 1'b0);
        chk({tag, "_sel_step"}, sel_cur, 32'(j + 1));
      end
    end
    din_valid = 1'b1; din = 1'b1;
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_out"}, out, w);
    chk({tag, "_ovalid"}, out_valid, 1'b1);
    chk({tag, "_sel_wrap"}, sel_cur, 4'h0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    start = poke;
    tick();
    start = 1'b0; din_valid = 1'b0; din = 1'b0;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_no_restart"}, busy, 1'b0);
    chk({tag, "_out_hold"}, out, w);
    chk({tag, "_ovalid_hold"}, out_valid, 1'b1);
    tick();
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_out"}, out, w);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; din = 1'b0; din_valid = 1'b0; sel_in = 4'h0;
    #12;
    chk("rst_out", out, 16'h0);
    chk("rst_sel", sel_cur, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovalid", out_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    // Addressed writes; second one also carries a start that must be ignored.
    mode = 1'b1; din = 1'b1; din_valid = 1'b1; sel_in = 4'hF;
    tick();
    chk("addr_w1", out, 16'h8000);
    chk("addr_done1", done, 1'b0);
    sel_in = 4'h3; start = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    chk("addr_w2", out, 16'h8008);
    chk("addr_busy", busy, 1'b0);
    chk("addr_done2", done, 1'b0);
    tick(); tick();
    chk("addr_hold", out, 16'h8008);
    chk("addr_ovalid", out_valid, 1'b0);
    chk("addr_nostart", busy, 1'b0);
    mode = 1'b0;

    run_scan("rt", 16'h5A46, 99, 0, 1'b0, 1'b0);
    run_scan("stall", 16'h5A46, 5, 3, 1'b0, 1'b0);
    run_scan("ign", 16'hC3A5, 99, 0, 1'b1, 1'b0);

    // Addressed write after a scan leaves out_valid untouched.
    mode = 1'b1; sel_in = 4'h0; din = 1'b0; din_valid = 1'b1;
    tick();
    mode = 1'b0; din_valid = 1'b0;
    chk("addr_post_out", out, 16'hC3A4);
    chk("addr_post_ovalid", out_valid, 1'b1);

    // Reset in the middle of a scan of all ones.
    start = 1'b1; tick(); start = 1'b0;
    din = 1'b1; din_valid = 1'b1;
    for (int j = 0; j < 7; j++) tick();
    chk("pre_rst_out", out, 16'h007F);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", out, 16'h0);
    chk("mid_rst_sel", sel_cur, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_ovalid", out_valid, 1'b0);
    din_valid = 1'b0; din = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 1'b0);
    run_scan("fresh", 16'h1234, 99, 0, 1'b0, 1'b0);

    // Start cycle carries a valid 1 that must be dropped.
    run_scan("drop", 16'h0000, 99, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_1x16_seq.md
Name: demux_1x16_seq

Overview:
- Sequenced 1-to-16 demultiplexer and deserializer. It is the receive-side counterpart of the 16:1 mux: it takes one bit per accepted beat and steers it into one of 16 registered output lanes.
- Two modes:
  - Auto-scan: lanes are filled 0..15 in order and the completed word is flagged.
  - Addressed: a single lane, chosen by sel_in, is written directly.
- Used to rebuild a 16-bit word that was serialized through mux_16x1 by stepping sel 0..15.

Parameters:
- N_OUT, 16, number of output lanes; the design must support a power of two only.
- SEL_W, 4, select width; must equal log2(N_OUT).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin an auto-scan capture.
- mode  input  1  0 = auto-scan, 1 = addressed; sampled in IDLE only.
- din  input  1  serial data bit.
- din_valid  input  1  din is valid this cycle.
- sel_in  input  SEL_W  target lane in addressed mode.
- out  output  N_OUT  registered lane values; bit k = lane k.
- sel_cur  output  SEL_W  lane that the next auto-scan beat will write.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.
- out_valid  output  1  level; high from scan completion until the next start.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out=0, sel_cur=0, busy=0, done=0, out_valid=0, state=IDLE.
  - Takes effect immediately, including mid-scan. No partial word survives.
- States: IDLE, SCAN, DONE.
- IDLE, start=1 and mode=0:
  - Next state SCAN; out<=0, sel_cur<=0, out_valid<=0.
  - din on the start cycle is NOT captured; capture begins the following cycle.
- IDLE, mode=1, din_valid=1, start=0:
  - out[sel_in]<=din; all other lanes hold.
  - State stays IDLE; done is not pulsed; out_valid is unchanged.
- IDLE, start=1 and mode=1: start is ignored; the addressed write still applies if din_valid=1.
- SCAN:
  - busy=1.
  - Each cycle with din_valid=1: out[sel_cur]<=din and sel_cur<=sel_cur+1, wrapping modulo N_OUT.
  - din_valid=0 stalls: no lane write, sel_cur holds. Gaps of any length are legal.
  - Beat written at sel_cur=N_OUT-1: next state DONE, sel_cur wraps to 0.
  - start, mode and sel_in are ignored while in SCAN.
- DONE (lasts exactly one cycle):
  - done=1, out_valid<=1, busy=0, next state IDLE.
  - din_valid in this cycle is ignored.
  - start in this cycle is ignored; it must be re-asserted in IDLE.
- Latency:
  - A bit accepted on edge t is visible on out after edge t.
  - Scan with no gaps: done is high in the cycle after the 16th accepted beat, i.e. 17 cycles after the start cycle.
- Hold behaviour: out holds its value indefinitely in IDLE. Only the next start or an addressed write changes it.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Round trip: serialize 16'h5A46 (decimal 23110) LSB-first as bits in[j], j=0..15, start with mode=0, din_valid=1 continuously -> busy high for 16 cycles; done pulses once; out=16'h5A46; out_valid=1; sel_cur=0.
- Stall: the same word with din_valid deasserted for 3 cycles after the 5th beat -> sel_cur holds at 5 during the gap; done arrives 3 cycles later; out=16'h5A46.
- Addressed: from reset, mode=1, write din=1 to sel_in=4'hF, then din=1 to 4'h3 -> out=16'h8008; done never pulses; out_valid=0.
- Ignore rules: start pulsed mid-scan and during DONE, and sel_in toggled during SCAN -> no restart, no stray lane writes, final out correct.
- Reset mid-scan: assert rst_n=0 after 7 beats of 16'hFFFF -> out, sel_cur, busy, done and out_valid all 0 immediately. A fresh scan of 16'h1234 then yields out=16'h1234.
- Boundary: start and din_valid=1 in the same IDLE cycle with din=1, then 16 beats of 0 -> out=16'h0000, confirming the start-cycle bit is dropped.
